// File: rtl/serial_word_assembler_pkg.sv
// Shared definitions for the serial word assembler: state encoding and default word width.
package serial_word_assembler_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int STATE_W       = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_COLLECT = 2'd0,
    ST_PARITY  = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/swa_bit_counter.sv
// Bit counter for the assembler: clears on request, counts accepted bits, and flags the
// final bit of a word so the count wraps to zero at word completion.
module swa_bit_counter
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = inc_i && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_assembler.sv
// Collects a serial bit stream into WIDTH-bit words presented with a valid/ready handshake.
// Define PARITY_CHECK_EN to add a trailing even-parity bit per frame and drive par_err.
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             par_err
);

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] par_out_q;
  logic             par_valid_q;
  logic             accept;
  logic             cnt_inc;
  logic             cnt_tc;

  // A word waiting in FULL blocks new bits unless it is being taken this same cycle.
  assign ser_ready = (state_q != ST_FULL) || par_ready;
  assign accept    = ser_valid && ser_ready && !flush;
  assign cnt_inc   = accept && (state_q != ST_PARITY);

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign sr_d = {sr_q[WIDTH-2:0], ser_in};
    end else begin : g_lsb_first
      assign sr_d = {ser_in, sr_q[WIDTH-1:1]};
    end
  endgenerate

  swa_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(flush),
    .inc_i(cnt_inc),
    .tc_o (cnt_tc)
  );

`ifdef PARITY_CHECK_EN
  logic par_err_q;
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign par_out   = par_out_q;
  assign par_valid = par_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      sr_q        <= '0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err_q   <= 1'b0;
`endif
    end else if (flush) begin
      state_q     <= ST_COLLECT;
      par_valid_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (accept) begin
            sr_q <= sr_d;
            if (cnt_tc) begin
              par_out_q <= sr_d;
`ifdef PARITY_CHECK_EN
              state_q   <= ST_PARITY;
`else
              state_q     <= ST_FULL;
              par_valid_q <= 1'b1;
`endif
            end
          end
        end
`ifdef PARITY_CHECK_EN
        ST_PARITY: begin
          if (accept) begin
            par_err_q   <= (^par_out_q) ^ ser_in;
            par_valid_q <= 1'b1;
            state_q     <= ST_FULL;
          end
        end
`endif
        ST_FULL: begin
          // A bit arriving with the handshake starts the next word without a bubble.
          if (par_ready) begin
            par_valid_q <= 1'b0;
            state_q     <= ST_COLLECT;
            if (accept) begin
              sr_q <= sr_d;
            end
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_assembler.sv
// Self-checking bench for serial_word_assembler: directed scenarios plus a randomized run
// checked against a frame-level reference model.
module tb_serial_word_assembler;

  localparam int W = 4;
`ifdef PARITY_CHECK_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic serIn = 1'b0, serValid = 1'b0, flush = 1'b0, parReady = 1'b0;
  logic serReady, parValid, parErr;
  logic [W-1:0] parOut;

  logic serIn1 = 1'b0, serValid1 = 1'b0, flush1 = 1'b0, parReady1 = 1'b0;
  logic serReady1, parValid1, parErr1;
  logic [W-1:0] parOut1;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1)) dutMsb (
    .clk(clk), .rst_n(rst_n), .ser_in(serIn), .ser_valid(serValid), .ser_ready(serReady),
    .flush(flush), .par_out(parOut), .par_valid(parValid), .par_ready(parReady), .par_err(parErr)
  );

  serial_word_assembler #(.WIDTH(W), .MSB_FIRST(0)) dutLsb (
    .clk(clk), .rst_n(rst_n), .ser_in(serIn1), .ser_valid(serValid1), .ser_ready(serReady1),
    .flush(flush1), .par_out(parOut1), .par_valid(parValid1), .par_ready(parReady1), .par_err(parErr1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    serValid = 1'b1;
    serIn    = b;
    tick();
    serValid = 1'b0;
  endtask

  // Sends a word first-bit-first in time order (w[3] first), plus its even-parity bit when enabled.
  task automatic drive_frame(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) drive_bit(w[i]);
`ifdef PARITY_CHECK_EN
    drive_bit(^w);
`endif
  endtask

  task automatic test_reset();
    checkCount++;
    if (parValid !== 1'b0 || parOut !== 4'b0000 || serReady !== 1'b1 || parErr !== 1'b0)
      $display("[TB] FAIL reset_state: valid=%b out=%b ready=%b err=%b, want 0 0000 1 0",
               parValid, parOut, serReady, parErr);
    else passCount++;

    parReady = 1'b1;
    drive_frame(4'b1111);
    checkCount++;
    if (parValid !== 1'b1 || parOut !== 4'b1111)
      $display("[TB] FAIL pre_reset_word: valid=%b out=%b, want 1 1111", parValid, parOut);
    else passCount++;

    drive_bit(1'b1);
    drive_bit(1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if (parValid !== 1'b0 || parOut !== 4'b0000)
      $display("[TB] FAIL async_reset: valid=%b out=%b, want 0 0000", parValid, parOut);
    else passCount++;
    #1 rst_n = 1'b1;
    tick();

    drive_frame(4'b0101);
    checkCount++;
    if (parValid !== 1'b1 || parOut !== 4'b0101)
      $display("[TB] FAIL post_reset_word: valid=%b out=%b, want 1 0101", parValid, parOut);
    else passCount++;
    tick();
  endtask

  task automatic test_basic();
    parReady = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    checkCount++;
    if (parValid !== 1'b0)
      $display("[TB] FAIL basic_early_valid: valid=%b, want 0", parValid);
    else passCount++;
    drive_bit(1'b1);
`ifdef PARITY_CHECK_EN
    drive_bit(1'b1);
`endif
    checkCount++;
    if (parValid !== 1'b1 || parOut !== 4'b1011 || parErr !== 1'b0)
      $display("[TB] FAIL basic_word: valid=%b out=%b err=%b, want 1 1011 0", parValid, parOut, parErr);
    else passCount++;
    tick();
    checkCount++;
    if (parValid !== 1'b0)
      $display("[TB] FAIL basic_one_cycle: valid=%b, want 0", parValid);
    else passCount++;
  endtask

  task automatic test_backpressure();
    parReady = 1'b0;
    drive_frame(4'b0110);
    serValid = 1'b1;
    serIn    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkCount++;
      if (serReady !== 1'b0)
        $display("[TB] FAIL bp_ser_ready: cycle %0d ready=%b, want 0", i, serReady);
      else passCount++;
      tick();
      checkCount++;
      if (parValid !== 1'b1 || parOut !== 4'b0110)
        $display("[TB] FAIL bp_hold: cycle %0d valid=%b out=%b, want 1 0110", i, parValid, parOut);
      else passCount++;
    end
    parReady = 1'b1;
    tick();
    checkCount++;
    if (parValid !== 1'b0)
      $display("[TB] FAIL bp_release: valid=%b, want 0", parValid);
    else passCount++;
    serIn = 1'b0; tick();
    serIn = 1'b0; tick();
    serIn = 1'b1; tick();
`ifdef PARITY_CHECK_EN
    serIn = 1'b1; tick();
`endif
    serValid = 1'b0;
    checkCount++;
    if (parValid !== 1'b1 || parOut !== 4'b0001)
      $display("[TB] FAIL bp_next_word: valid=%b out=%b, want 1 0001", parValid, parOut);
    else passCount++;
    tick();
  endtask

  task automatic test_streaming();
    logic [W-1:0] words [2];
    logic stream [$];
    logic expValid;
    words[0] = 4'b1100;
    words[1] = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      for (int i = W - 1; i >= 0; i--) stream.push_back(words[k][i]);
`ifdef PARITY_CHECK_EN
      stream.push_back(^words[k]);
`endif
    end
    parReady = 1'b1;
    for (int i = 0; i < stream.size(); i++) begin
      serValid = 1'b1;
      serIn    = stream[i];
      tick();
      expValid = ((i + 1) % FRAME) == 0;
      checkCount++;
      if (parValid !== expValid)
        $display("[TB] FAIL stream_valid: bit %0d valid=%b, want %b", i, parValid, expValid);
      else passCount++;
      if (expValid) begin
        checkCount++;
        if (parOut !== words[i / FRAME])
          $display("[TB] FAIL stream_word: bit %0d out=%b, want %b", i, parOut, words[i / FRAME]);
        else passCount++;
      end
    end
    serValid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    parReady = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b0);
    flush = 1'b1; serValid = 1'b1; serIn = 1'b1;
    tick();
    flush = 1'b0; serValid = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    checkCount++;
    if (parValid !== 1'b0)
      $display("[TB] FAIL flush_partial_emitted: valid=%b, want 0", parValid);
    else passCount++;
    drive_bit(1'b0);
`ifdef PARITY_CHECK_EN
    drive_bit(1'b1);
`endif
    checkCount++;
    if (parValid !== 1'b1 || parOut !== 4'b1110)
      $display("[TB] FAIL flush_word: valid=%b out=%b, want 1 1110", parValid, parOut);
    else passCount++;
    tick();

    parReady = 1'b0;
    drive_frame(4'b1001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkCount++;
    if (parValid !== 1'b0 || parOut !== 4'b1001 || serReady !== 1'b1)
      $display("[TB] FAIL flush_full: valid=%b out=%b ready=%b, want 0 1001 1", parValid, parOut, serReady);
    else passCount++;
    parReady = 1'b1;
  endtask

  task automatic test_lsb_first();
    logic seq [$];
    seq = '{1'b1, 1'b0, 1'b0, 1'b0};
`ifdef PARITY_CHECK_EN
    seq.push_back(1'b1);
`endif
    parReady1 = 1'b1;
    foreach (seq[i]) begin
      serValid1 = 1'b1;
      serIn1    = seq[i];
      tick();
    end
    serValid1 = 1'b0;
    checkCount++;
    if (parValid1 !== 1'b1 || parOut1 !== 4'b0001 || parErr1 !== 1'b0)
      $display("[TB] FAIL lsb_first: valid=%b out=%b err=%b, want 1 0001 0", parValid1, parOut1, parErr1);
    else passCount++;
    tick();
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    parReady = 1'b0;
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    checkCount++;
    if (parValid !== 1'b1 || parOut !== 4'b1011 || parErr !== 1'b0)
      $display("[TB] FAIL parity_good: valid=%b out=%b err=%b, want 1 1011 0", parValid, parOut, parErr);
    else passCount++;
    parReady = 1'b1;
    tick();
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0);
    checkCount++;
    if (parValid !== 1'b1 || parOut !== 4'b1011 || parErr !== 1'b1)
      $display("[TB] FAIL parity_bad: valid=%b out=%b err=%b, want 1 1011 1", parValid, parOut, parErr);
    else passCount++;
    tick();
  endtask
`endif

  // Reference model: accepted bits gather into a frame; a complete frame becomes a pending word.
  task automatic test_random();
    logic frameBits [$];
    logic haveWord;
    logic [W-1:0] wordExp;
    logic errExp;
    logic expReady;
    int acc;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    haveWord = 1'b0;
    wordExp  = '0;
    errExp   = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      serValid = ($urandom_range(0, 3) != 0);
      serIn    = 1'($urandom_range(0, 1));
      parReady = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 39) == 0);
      #1;
      expReady = !haveWord || parReady;
      checkCount++;
      if (serReady !== expReady || parValid !== haveWord)
        $display("[TB] FAIL rand_ctrl: cycle %0d ready=%b valid=%b, want %b %b",
                 cyc, serReady, parValid, expReady, haveWord);
      else passCount++;
      if (haveWord) begin
        checkCount++;
        if (parOut !== wordExp || parErr !== errExp)
          $display("[TB] FAIL rand_word: cycle %0d out=%b err=%b, want %b %b",
                   cyc, parOut, parErr, wordExp, errExp);
        else passCount++;
      end
      if (flush) begin
        frameBits.delete();
        haveWord = 1'b0;
      end else begin
        if (serValid && expReady) frameBits.push_back(serIn);
        if (haveWord && parReady) haveWord = 1'b0;
        if (frameBits.size() == FRAME) begin
          acc = 0;
          for (int k = 0; k < W; k++) acc = acc * 2 + int'(frameBits[k]);
          wordExp = W'(acc);
`ifdef PARITY_CHECK_EN
          acc = 0;
          foreach (frameBits[k]) acc += int'(frameBits[k]);
          errExp = 1'(acc % 2);
`endif
          haveWord = 1'b1;
          frameBits.delete();
        end
      end
      @(posedge clk);
      #1;
    end
    flush    = 1'b0;
    serValid = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_streaming();
    test_flush();
    test_lsb_first();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
